// File: rtl/tick_phase_timer.sv
// ---------------------------------------------------------------------------
// tick_phase_timer
//
// Phase countdown timer driven by a slow, asynchronous "seconds" clock.
// clk_slow is never used as a clock. It is sampled as data through a
// SYNC_STAGES-deep synchronizer and a history flop. Each rising edge then
// becomes a one-cycle registered tick. Every PRESCALE ticks in RUN, the
// remaining-seconds count drops by one. Reaching zero enters DONE and pulses
// done for one cycle.
//
// Parameters
//   SYNC_STAGES  synchronizer depth on clk_slow (2..4)
//   PRESCALE     ticks per count decrement (2..1023)
//
// Ports
//   mclk      in   system clock, all state on its rising edge
//   rst       in   asynchronous reset, active low
//   clk_slow  in   slow clock, asynchronous to mclk, sampled as data
//   load      in   load load_val into count (IDLE/DONE only)
//   load_val  in   [11:0] phase duration in seconds
//   start     in   begin counting from IDLE, resume from PAUSE
//   pause     in   hold counting (RUN only)
//   clear     in   abort, return to IDLE with count 0
//   tick      out  one-cycle pulse per clk_slow rising edge
//   count     out  [11:0] remaining seconds
//   busy      out  high in RUN or PAUSE
//   done      out  one-cycle pulse on entry to DONE
//   state     out  [1:0] IDLE=00 RUN=01 PAUSE=10 DONE=11
//
// Control priority each cycle is clear > load > start > pause. Only the
// highest-priority asserted input has any effect. If that input is not
// meaningful in the current state (for example load in RUN), the cycle
// behaves as if no control were asserted.
// ---------------------------------------------------------------------------
module tick_phase_timer #(
    parameter int SYNC_STAGES = 2,
    parameter int PRESCALE    = 190
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic        clk_slow,
    input  logic        load,
    input  logic [11:0] load_val,
    input  logic        start,
    input  logic        pause,
    input  logic        clear,
    output logic        tick,
    output logic [11:0] count,
    output logic        busy,
    output logic        done,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [9:0] PRESC_LAST = 10'(PRESCALE - 1);

    // -----------------------------------------------------------------------
    // clk_slow synchronizer, history flop and tick generation
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   tick_q;

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], clk_slow};
            hist_q <= sync_q[SYNC_STAGES-1];
            // Rising edge seen at the end of the chain. The history flop
            // holds the previous value of the last stage.
            tick_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
        end
    end

    // -----------------------------------------------------------------------
    // Phase state machine: registers
    // -----------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [11:0] count_q, count_d;
    logic [9:0]  presc_q, presc_d;
    logic        done_q,  done_d;

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Phase state machine: next state
    // -----------------------------------------------------------------------
    // Priority-resolved controls: at most one of these is high in a cycle.
    logic ctrl_load;
    logic ctrl_start;
    logic ctrl_pause;

    assign ctrl_load  = ~clear & load;
    assign ctrl_start = ~clear & ~load & start;
    assign ctrl_pause = ~clear & ~load & ~start & pause;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        done_d  = 1'b0;

        if (clear) begin
            state_d = ST_IDLE;
            count_d = '0;
            presc_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ctrl_load) begin
                        count_d = load_val;
                        presc_d = '0;
                    end else if (ctrl_start) begin
                        // A zero-length phase finishes at once and never
                        // enters RUN, so count can never wrap.
                        if (count_q != 12'd0) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    if (ctrl_pause) begin
                        // The tick in this cycle, if any, is dropped.
                        state_d = ST_PAUSE;
                    end else if (tick_q) begin
                        if (presc_q == PRESC_LAST) begin
                            presc_d = '0;
                            count_d = count_q - 12'd1;
                            if (count_q == 12'd1) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            presc_d = presc_q + 10'd1;
                        end
                    end
                end

                ST_PAUSE: begin
                    if (ctrl_start) begin
                        state_d = ST_RUN;
                    end
                end

                ST_DONE: begin
                    if (ctrl_load) begin
                        state_d = ST_IDLE;
                        count_d = load_val;
                        presc_d = '0;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign tick  = tick_q;
    assign count = count_q;
    assign done  = done_q;
    assign state = state_q;
    assign busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);

endmodule

// File: doc/tick_phase_timer.md
TICK_PHASE_TIMER -- requirements
Module: tick_phase_timer

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on clk_slow (legal range 2..4).
REQ-002 The block SHALL have parameter PRESCALE, default 190, meaning the number of ticks per count decrement (legal range 2..1023).
REQ-003 The block SHALL have port mclk, input, 1 bit: the single system clock; all state is clocked on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-005 The block SHALL have port clk_slow, input, 1 bit: the divided slow clock, treated as asynchronous to mclk and sampled as data, never used as a clock.
REQ-006 The block SHALL have port load, input, 1 bit: load load_val into count.
REQ-007 The block SHALL have port load_val, input, 12 bits: the phase duration in seconds.
REQ-008 The block SHALL have port start, input, 1 bit: begin or resume counting.
REQ-009 The block SHALL have port pause, input, 1 bit: hold counting.
REQ-010 The block SHALL have port clear, input, 1 bit: abort and return to IDLE.
REQ-011 The block SHALL have port tick, output, 1 bit: a one-mclk-cycle pulse per rising edge of clk_slow.
REQ-012 The block SHALL have port count, output, 12 bits: the remaining seconds.
REQ-013 The block SHALL have port busy, output, 1 bit: high in RUN or PAUSE.
REQ-014 The block SHALL have port done, output, 1 bit: a one-mclk-cycle pulse on entry to DONE.
REQ-015 The block SHALL have port state, output, 2 bits: IDLE=00, RUN=01, PAUSE=10, DONE=11.

Function
REQ-016 clk_slow SHALL pass through a SYNC_STAGES-deep flop chain followed by one history flop.
REQ-017 tick SHALL be registered and high for exactly one mclk cycle when the last sync stage is 1 and the history flop is 0. With SYNC_STAGES=2, tick is high in the cycle following the 3rd mclk edge after the first edge that samples clk_slow=1.
REQ-018 tick SHALL run in every state, independent of the state machine.
REQ-019 A 10-bit prescaler presc SHALL increment on tick in RUN only. When presc==PRESCALE-1 and tick is high, presc SHALL become 0 and count SHALL decrement by 1.
REQ-020 Control priority SHALL be, each cycle: clear > load > start > pause. Only the highest-priority asserted input acts.
REQ-021 clear, in any state, SHALL set state to IDLE, count to 0 and presc to 0 on the next edge.
REQ-022 load in IDLE or DONE SHALL set count to load_val, presc to 0 and state to IDLE. load in RUN or PAUSE SHALL be ignored.
REQ-023 In IDLE, start with count!=0 SHALL go to RUN. In IDLE, start with count==0 SHALL go to DONE and pulse done.
REQ-024 In RUN, pause SHALL go to PAUSE with presc and count frozen. Ticks in PAUSE SHALL be ignored.
REQ-025 In PAUSE, start SHALL return to RUN and resume from the frozen presc value.
REQ-026 In RUN, the decrement that takes count from 1 to 0 SHALL move to DONE in the same edge, and done SHALL be high in the next cycle only.
REQ-027 count SHALL never wrap: no decrement occurs outside RUN, and RUN is never entered with count==0.
REQ-028 DONE SHALL hold, with count=0, until clear or load. start in DONE SHALL be ignored.
REQ-029 busy SHALL equal (state==RUN)|(state==PAUSE), decoded from registered state.

Reset
REQ-030 rst=0 SHALL immediately force: all sync and history flops 0, presc=0, count=0, state=IDLE, tick=0, done=0, busy=0.
REQ-031 Reset asserted mid-RUN SHALL abandon the phase with no done pulse.
REQ-032 If clk_slow is 1 at reset release, one tick SHALL occur after the sync latency; this is intended behaviour.

Verification
REQ-033 Drive clk_slow as a square wave of period 40 mclk -> exactly one 1-cycle tick per period, at the latency given in REQ-017, with no ticks on falling edges.
REQ-034 Set PRESCALE=4, load_val=3, then start -> count goes 3,2,1,0 on every 4th tick; done pulses once at 12 ticks; state goes 01 then 11; busy falls with the DONE entry.
REQ-035 While RUN with count=2 and presc=2, assert pause for 10 ticks, then start -> count and presc are unchanged during PAUSE, and the next decrement occurs 2 ticks after resume.
REQ-036 Assert load_val=0, then start -> DONE the next edge with a done pulse and no RUN cycle; start in DONE is ignored; load=5 returns to IDLE with count=5.
REQ-037 Assert clear and start in the same cycle during RUN -> IDLE with count=0. Assert load during RUN -> ignored.
REQ-038 Assert rst=0 asynchronously between mclk edges during RUN -> all outputs zero before the next mclk edge, and no done pulse after release.
